// File: rtl/cic_interpolator.sv
// Order-2 CIC interpolator: two combs at the input rate, zero-stuffing by
// INTERP, two integrators at the output rate, then divide-by-INTERP with
// optional round-half-up and saturation back to the sample width.
module cic_interpolator #(
    parameter int    DIN_WIDTH = 32,
    parameter int    DIN_POINT = 31,
    parameter int    INTERP    = 16,
    parameter string APPROX    = "nearest"
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DIN_WIDTH-1:0] din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic signed [DIN_WIDTH-1:0] dout,
    output logic                        dout_valid
);
    localparam int LOG2I   = $clog2(INTERP);
    localparam int W       = DIN_WIDTH + 2 + LOG2I;   // internal datapath width
    localparam int SW      = W + 1 - LOG2I;           // width after the normalizing shift
    localparam int NSTAGES = 2;
    localparam bit NEAREST = (APPROX == "nearest");
    localparam logic [LOG2I-1:0] P_LAST = LOG2I'(INTERP - 1);
    localparam logic signed [W:0] ROUND = NEAREST ? ((W+1)'(1) << (LOG2I - 1)) : '0;

    // Elaboration-time parameter sanity checks.
    if (INTERP < 2 || (INTERP & (INTERP - 1)) != 0) begin : g_bad_interp
        $error("cic_interpolator: INTERP must be a power of two >= 2");
    end
    if (DIN_POINT < 0 || DIN_POINT >= DIN_WIDTH) begin : g_bad_point
        $error("cic_interpolator: DIN_POINT must lie inside the sample width");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state_q;
    logic [LOG2I-1:0] p_q;
    logic             accept;
    logic             phase0;

    logic signed [W-1:0] comb_in  [0:NSTAGES];
    logic signed [W-1:0] integ_in [0:NSTAGES];
    logic signed [W-1:0] inject_q;
    logic signed [W-1:0] integ_last;

    logic                        upd_q;
    logic signed [DIN_WIDTH-1:0] dout_q;
    logic                        dout_valid_q;

    // Handshake: a new sample is taken when idle or on the last phase.
    assign din_ready = ((state_q == ST_IDLE) || (p_q == P_LAST)) && !rst;
    assign accept    = din_valid && din_ready;
    assign phase0    = (state_q == ST_RUN) && (p_q == '0);

    // Phase sequencer: IDLE until a sample arrives, then INTERP output cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_RUN;
                        p_q     <= '0;
                    end
                end
                default: begin
                    if (p_q == P_LAST) begin
                        p_q <= '0;
                        if (!accept) begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        p_q <= p_q + LOG2I'(1);
                    end
                end
            endcase
        end
    end

    // Comb chain input is the sign-extended sample.
    assign comb_in[0] = {{(W - DIN_WIDTH){din[DIN_WIDTH-1]}}, din};

    // Integrator chain input: comb output in phase 0, zero (stuffed) otherwise.
    assign integ_in[0] = phase0 ? inject_q : '0;

    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_comb
        logic signed [W-1:0] dly_q;
        assign comb_in[gi+1] = comb_in[gi] - dly_q;

        // Comb delay line advances only when a sample is accepted.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dly_q <= '0;
            end else if (accept) begin
                dly_q <= comb_in[gi];
            end
        end
    end

    // Comb output captured at acceptance, injected in the following phase-0 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inject_q <= '0;
        end else if (accept) begin
            inject_q <= comb_in[NSTAGES];
        end
    end

    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_integ
        logic signed [W-1:0] acc_q;
        // Each stage feeds its freshly updated sum to the next stage.
        assign integ_in[gi+1] = acc_q + integ_in[gi];

        // Integrators run only in RUN cycles and hold while idle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
            end else if (state_q == ST_RUN) begin
                acc_q <= integ_in[gi+1];
            end
        end

        if (gi == NSTAGES - 1) begin : g_last
            assign integ_last = acc_q;
        end
    end

    logic signed [W:0]           rnd_sum;
    logic signed [SW-1:0]        shifted;
    logic [SW-DIN_WIDTH:0]       top_bits;
    logic signed [DIN_WIDTH-1:0] sat_d;

    // Divide by INTERP (drop LSBs after optional rounding), then saturate.
    always_comb begin
        rnd_sum  = {integ_last[W-1], integ_last} + ROUND;
        shifted  = SW'(rnd_sum >>> LOG2I);
        top_bits = shifted[SW-1:DIN_WIDTH-1];
        if (top_bits == '0 || top_bits == '1) begin
            sat_d = shifted[DIN_WIDTH-1:0];
        end else if (shifted[SW-1]) begin
            sat_d = {1'b1, {(DIN_WIDTH-1){1'b0}}};
        end else begin
            sat_d = {1'b0, {(DIN_WIDTH-1){1'b1}}};
        end
    end

    // Output register: one cycle behind the integrators; holds when not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            upd_q        <= (state_q == ST_RUN);
            dout_valid_q <= upd_q;
            if (upd_q) begin
                dout_q <= sat_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (INTERP=4, DIN_WIDTH=32), with a
// second instance built for truncation to cover both normalization modes.
module tb_cic_interpolator;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] din;
    logic               din_valid;
    logic               din_ready,   t_din_ready;
    logic signed [31:0] dout,        t_dout;
    logic               dout_valid,  t_dout_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] outq[$];
    logic [31:0] toutq[$];

    logic [31:0] exp_imp [0:7] = '{32'h10000000, 32'h20000000, 32'h30000000, 32'h40000000,
                                   32'h30000000, 32'h20000000, 32'h10000000, 32'h00000000};
    logic [31:0] exp_neg [0:7] = '{32'hF0000000, 32'hE0000000, 32'hD0000000, 32'hC0000000,
                                   32'hD0000000, 32'hE0000000, 32'hF0000000, 32'h00000000};
    logic [31:0] exp_near [0:7] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0};
    logic [31:0] exp_trnc [0:7] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};

    cic_interpolator #(.DIN_WIDTH(32), .DIN_POINT(31), .INTERP(4), .APPROX("nearest")) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    cic_interpolator #(.DIN_WIDTH(32), .DIN_POINT(31), .INTERP(4), .APPROX("truncate")) dut_trunc (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (t_din_ready),
        .dout       (t_dout),
        .dout_valid (t_dout_valid)
    );

    always #5 clk = ~clk;

    // Collect every valid output sample away from the active edge.
    always @(negedge clk) begin
        if (dout_valid)   outq.push_back(dout);
        if (t_dout_valid) toutq.push_back(t_dout);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample after 'gap' idle cycles and wait (bounded) for acceptance.
    task automatic send(input logic [31:0] v, input int gap);
        din_valid = 1'b0;
        repeat (gap) tick();
        din       = v;
        din_valid = 1'b1;
        for (int i = 0; i < 20 && !din_ready; i++) tick();
        n_checks++;
        if (din_ready !== 1'b1) $display("FAIL send_timeout din_ready=%b required 1", din_ready);
        else n_pass++;
        tick();
        $display("sent %h after %0d idle cycles", v, gap);
    endtask

    task automatic drain();
        din_valid = 1'b0;
        din       = '0;
        repeat (12) tick();
    endtask

    task automatic play(input logic [31:0] first, input int g1, input int g2, input int g3);
        send(first, 0);
        send(32'h0, g1);
        send(32'h0, g2);
        send(32'h0, g3);
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; din_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (dout !== 32'h0) $display("FAIL reset_dout got %h want 0", dout); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid got %b want 0", dout_valid); else n_pass++;
        n_checks++; if (din_ready !== 1'b0) $display("FAIL reset_din_ready got %b want 0", din_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (din_ready !== 1'b1) $display("FAIL idle_din_ready got %b want 1", din_ready); else n_pass++;
    endtask

    task automatic test_impulse();
        outq.delete();
        play(32'h40000000, 0, 0, 0);
        n_checks++; if (outq.size() != 16) $display("FAIL impulse_count got %0d want 16", outq.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] want;
            want = (i < 8) ? exp_imp[i] : 32'h0;
            n_checks++;
            if (outq[i] !== want) $display("FAIL impulse[%0d] got %h want %h", i, outq[i], want);
            else n_pass++;
        end
    endtask

    task automatic test_negative();
        outq.delete();
        play(32'hC0000000, 0, 0, 0);
        n_checks++; if (outq.size() != 16) $display("FAIL negative_count got %0d want 16", outq.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (outq[i] !== exp_neg[i]) $display("FAIL negative[%0d] got %h want %h", i, outq[i], exp_neg[i]);
            else n_pass++;
        end
    endtask

    task automatic test_handshake();
        int ready_cnt;
        ready_cnt = 0;
        outq.delete();
        din       = '0;
        din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (din_ready) ready_cnt++;
            tick();
            n_checks++;
            if (dout_valid !== (i >= 2)) $display("FAIL handshake_valid[%0d] got %b want %b", i, dout_valid, (i >= 2));
            else n_pass++;
        end
        drain();
        n_checks++; if (ready_cnt != 4) $display("FAIL handshake_ready_count got %0d want 4", ready_cnt); else n_pass++;
        n_checks++; if (outq.size() != 16) $display("FAIL handshake_out_count got %0d want 16", outq.size()); else n_pass++;
    endtask

    task automatic test_gaps();
        outq.delete();
        play(32'h40000000, 6, 4, 9);
        n_checks++; if (outq.size() != 16) $display("FAIL gaps_count got %0d want 16", outq.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] want;
            want = (i < 8) ? exp_imp[i] : 32'h0;
            n_checks++;
            if (outq[i] !== want) $display("FAIL gaps[%0d] got %h want %h", i, outq[i], want);
            else n_pass++;
        end
    endtask

    task automatic test_rounding();
        outq.delete();
        toutq.delete();
        send(32'h1, 0);
        send(32'h0, 0);
        drain();
        n_checks++; if (outq.size() != 8) $display("FAIL round_count got %0d want 8", outq.size()); else n_pass++;
        n_checks++; if (toutq.size() != 8) $display("FAIL trunc_count got %0d want 8", toutq.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (outq[i] !== exp_near[i]) $display("FAIL round_nearest[%0d] got %h want %h", i, outq[i], exp_near[i]);
            else n_pass++;
            n_checks++;
            if (toutq[i] !== exp_trnc[i]) $display("FAIL round_truncate[%0d] got %h want %h", i, toutq[i], exp_trnc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midburst();
        send(32'h40000000, 0);
        din_valid = 1'b0;
        din       = '0;
        tick();
        tick();
        n_checks++; if (dout_valid !== 1'b1) $display("FAIL midburst_pre_valid got %b want 1", dout_valid); else n_pass++;
        n_checks++; if (dout !== 32'h10000000) $display("FAIL midburst_pre_dout got %h want 10000000", dout); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (dout !== 32'h0) $display("FAIL midburst_dout got %h want 0", dout); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL midburst_dout_valid got %b want 0", dout_valid); else n_pass++;
        n_checks++; if (din_ready !== 1'b0) $display("FAIL midburst_din_ready got %b want 0", din_ready); else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        #1;
        outq.delete();
        play(32'h40000000, 0, 0, 0);
        n_checks++; if (outq.size() != 16) $display("FAIL after_reset_count got %0d want 16", outq.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (outq[i] !== exp_imp[i]) $display("FAIL after_reset[%0d] got %h want %h", i, outq[i], exp_imp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_dc();
        outq.delete();
        for (int k = 0; k < 6; k++) send(32'h7FFFFFFF, 0);
        drain();
        n_checks++; if (outq.size() != 24) $display("FAIL dc_count got %0d want 24", outq.size()); else n_pass++;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] want;
            case (i)
                0:       want = 32'h20000000;
                1:       want = 32'h40000000;
                2:       want = 32'h5FFFFFFF;
                default: want = 32'h7FFFFFFF;
            endcase
            n_checks++;
            if (outq[i] !== want) $display("FAIL dc[%0d] got %h want %h", i, outq[i], want);
            else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        test_reset();
        test_impulse();
        test_negative();
        test_handshake();
        test_gaps();
        test_rounding();
        test_reset_midburst();
        test_dc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 32: signed sample width, in and out.
REQ-002 SHALL have parameter DIN_POINT, default 31: binary point of din/dout; informational only, no effect on arithmetic.
REQ-003 SHALL have parameter INTERP, default 16: interpolation factor, power of two, >= 2.
REQ-004 SHALL have parameter APPROX, default "nearest": "truncate" or "nearest"; any other value behaves as "truncate".
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port din, input, DIN_WIDTH, signed: low-rate input sample.
REQ-008 SHALL have port din_valid, input, 1: din qualifier.
REQ-009 SHALL have port din_ready, output, 1: sample accepted on an edge where din_valid && din_ready.
REQ-010 SHALL have port dout, output, DIN_WIDTH, signed: high-rate interpolated sample, registered.
REQ-011 SHALL have port dout_valid, output, 1, registered: dout qualifier; no output backpressure.

Function
REQ-012 SHALL implement a fixed order-2 CIC interpolator: two combs (differential delay 1) at input rate, zero-stuffing by INTERP, then two integrators at output rate.
REQ-013 SHALL update comb stages only on accepting edges; comb and integrator registers SHALL hold otherwise.
REQ-014 SHALL use internal width W = DIN_WIDTH + 2 + log2(INTERP), two's complement, modular wrap-around with no saturation inside combs and integrators.
REQ-015 SHALL have a 2-state FSM: IDLE and RUN, with phase counter p over 0..INTERP-1.
REQ-016 SHALL transition IDLE -> RUN on an accepting edge, setting p=0.
REQ-017 In RUN, p SHALL increment each cycle.
REQ-018 At p=INTERP-1 with an accepting edge, SHALL set p=0 and stay in RUN (back-to-back).
REQ-019 At p=INTERP-1 without an accepting edge, SHALL go to IDLE.
REQ-020 din_ready SHALL be combinational: (state==IDLE || p==INTERP-1) && !rst.
REQ-021 Integrator 1 SHALL add the comb-2 output only in the phase-0 cycle and add zero in other RUN cycles; integrator 2 SHALL add integrator 1 every RUN cycle; both SHALL hold in IDLE.
REQ-022 SHALL produce exactly INTERP dout_valid cycles per accepted sample; the first valid output SHALL appear 2 edges after the accepting edge.
REQ-023 Back-to-back acceptance SHALL give continuous dout_valid with no gaps.
REQ-024 Input gaps SHALL be transparent: the output sequence with gaps removed SHALL equal the gapless output sequence.
REQ-025 Normalization SHALL divide integrator 2 by INTERP (gain of order-2 CIC interpolation) by dropping log2(INTERP) LSBs.
REQ-026 With "nearest", SHALL add 2^(log2(INTERP)-1) before the shift (round half up).
REQ-027 The normalized result SHALL saturate to [-2^(DIN_WIDTH-1), 2^(DIN_WIDTH-1)-1].
REQ-028 dout SHALL hold its last value while dout_valid=0.

Reset
REQ-029 While rst is high, SHALL immediately (asynchronously) clear all combs, integrators, p, and dout to 0, and set state=IDLE, dout_valid=0, din_ready=0.
REQ-030 A reset mid-burst SHALL abort remaining outputs.
REQ-031 After rst deasserts, the first accepted sample SHALL behave as after power-up.

Verification (INTERP=4, DIN_WIDTH=32 unless stated)
REQ-032 Impulse: din=0x40000000 then zeros, back-to-back -> dout = 0x10000000, 0x20000000, 0x30000000, 0x40000000, 0x30000000, 0x20000000, 0x10000000, then 0.
REQ-033 DC: constant din=0x7FFFFFFF, "nearest" -> settles to 0x7FFFFFFF; no wrap to negative (saturation check).
REQ-034 Gaps: same impulse stream with random din_valid idle cycles -> identical dout sequence; dout_valid asserted exactly 4 cycles per accepted sample.
REQ-035 Handshake: din_valid held high -> din_ready high 1 cycle in 4; dout_valid continuous; first dout_valid 2 edges after first acceptance.
REQ-036 Reset mid-burst: rst pulse at p=2 -> dout=0, dout_valid=0, and din_ready=0 without waiting for a clock edge; next impulse reproduces the REQ-032 sequence.
REQ-037 Rounding: INTERP=4, single sample din=0x00000001, "nearest" -> outputs 0,1,1,1,1,1,0 (from 1/4, 2/4, 3/4, 4/4, 3/4, 2/4, 1/4); "truncate" -> 0,0,0,1,0,0,0.
